// File: rtl/fifo_pkg.sv
// fifo_pkg: reader FSM state encoding and default widths shared by the FIFO stream reader files
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry in-order buffer (clk/rst, push+din in, pop in, occ/head/overflow out); same-cycle push+pop allowed
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head,
  output logic         overflow
);
  logic [W-1:0] d1;
  logic pop_i, push_i;
  logic [1:0] wi;
  always_comb begin
    pop_i = pop && occ != 2'd0;
    push_i = push && (occ != 2'd2 || pop_i);
    overflow = push && !push_i;
    wi = occ - {1'b0, pop_i};
  end
  always_ff @(posedge clk)
    if (rst) begin
      occ <= 2'd0;
      head <= '0;
      d1 <= '0;
    end else begin
      occ <= occ + {1'b0, push_i} - {1'b0, pop_i};
      if (pop_i) head <= d1;
      if (push_i && wi == 2'd0) head <= din;
      if (push_i && wi == 2'd1) d1 <= din;
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port (r_en/empty/data_out/read_error) onto a valid/ready stream (m_*) with rd_count, err_sticky, busy
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  read_error,
  output logic                  r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_sticky,
  output logic                  busy
);
  state_t state, state_n;
  logic inflight, pop, overflow;
  logic [1:0] occ;
  logic [2:0] lvl;
  logic [DATA_WIDTH-1:0] head;
  always_comb begin
    m_valid = rrst_n && occ != 2'd0;
    m_data = rrst_n ? head : '0;
    pop = m_valid && m_ready;
    lvl = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    r_en = rrst_n && state == ACTIVE && en && !empty && lvl < 3'd2;
    busy = rrst_n && state != IDLE;
    state_n = en ? ACTIVE : state == ACTIVE ? FLUSH : state == FLUSH && (occ != 2'd0 || inflight) ? FLUSH : IDLE;
  end
  always_ff @(posedge rclk)
    if (!rrst_n) begin
      state <= IDLE;
      inflight <= 1'b0;
      rd_count <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= r_en;
      rd_count <= rd_count + CNT_WIDTH'(pop);
      err_sticky <= err_sticky | read_error | overflow;
    end
  stream_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk(rclk),
    .rst(!rrst_n),
    .push(inflight),
    .din(data_out),
    .pop(pop),
    .occ(occ),
    .head(head),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed vector and sequence checks of fifo_stream_reader against a behavioural FIFO
module tb_fifo_stream_reader;
  logic rclk = 0, rrst_n = 0, en = 0, read_error = 0, m_ready = 0, inf = 0;
  logic empty, r_en, m_valid, err_sticky, busy;
  logic [7:0] data_out = 0, m_data;
  logic [15:0] rd_count;
  logic [7:0] mem [64];
  logic [7:0] got [$];
  int rd_ptr = 0, wr_ptr = 0, errors = 0, checks = 0, nre = 0, viol = 0;
  typedef struct {
    logic en;
    logic rdy;
    logic r_en;
    logic mv;
    logic [7:0] md;
    logic [15:0] cnt;
  } vec_t;
  vec_t tv [8];
  fifo_stream_reader dut (
    .rclk(rclk),
    .rrst_n(rrst_n),
    .en(en),
    .empty(empty),
    .data_out(data_out),
    .read_error(read_error),
    .r_en(r_en),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .rd_count(rd_count),
    .err_sticky(err_sticky),
    .busy(busy)
  );
  always #5 rclk = ~rclk;
  assign empty = !inf && (rd_ptr == wr_ptr);
  always @(posedge rclk)
    if (r_en) begin
      data_out <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + 1;
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = first + 8'(i);
      wr_ptr++;
    end
  endtask
  task automatic cyc(input logic e, input logic r);
    @(posedge rclk);
    #1;
    en = e;
    m_ready = r;
    @(negedge rclk);
    if (m_valid && m_ready) got.push_back(m_data);
    if (r_en) nre++;
    if (r_en && empty) viol++;
  endtask
  task automatic rst();
    @(posedge rclk);
    #1;
    rrst_n = 0;
    @(negedge rclk);
    chk("rst_r_en", r_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    @(posedge rclk);
    #1;
    rrst_n = 1;
    en = 0;
    m_ready = 0;
    read_error = 0;
    inf = 0;
    wr_ptr = rd_ptr;
    got.delete();
    nre = 0;
    @(negedge rclk);
    chk("post_rst_rd_count", rd_count, 0);
    chk("post_rst_err", err_sticky, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_m_valid", m_valid, 0);
  endtask
  initial begin
    tv[0] = '{1, 1, 0, 0, 8'h00, 16'd0};
    tv[1] = '{1, 1, 1, 0, 8'h00, 16'd0};
    tv[2] = '{1, 1, 1, 0, 8'h00, 16'd0};
    tv[3] = '{1, 1, 1, 1, 8'h01, 16'd0};
    tv[4] = '{1, 1, 1, 1, 8'h02, 16'd1};
    tv[5] = '{1, 1, 0, 1, 8'h03, 16'd2};
    tv[6] = '{1, 1, 0, 1, 8'h04, 16'd3};
    tv[7] = '{1, 1, 0, 0, 8'h00, 16'd4};
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst();
    load(8'h01, 4);
    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].en, tv[i].rdy);
      chk($sformatf("stream_r_en[%0d]", i), r_en, tv[i].r_en);
      chk($sformatf("stream_m_valid[%0d]", i), m_valid, tv[i].mv);
      if (tv[i].mv) chk($sformatf("stream_m_data[%0d]", i), m_data, tv[i].md);
      chk($sformatf("stream_rd_count[%0d]", i), rd_count, tv[i].cnt);
    end
    rst();
    load(8'hA0, 6);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0);
      if (k >= 3) chk($sformatf("hold_m_data[%0d]", k), m_data, 8'hA0);
    end
    chk("hold_r_en_reads", nre, 2);
    chk("hold_m_valid", m_valid, 1);
    for (int k = 0; k < 20 && got.size() < 6; k++) cyc(1, 1);
    chk("release_words", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk($sformatf("release_order[%0d]", i), got[i], 8'hA0 + 8'(i));
    cyc(1, 1);
    chk("release_rd_count", rd_count, 6);
    rst();
    load(8'h55, 3);
    cyc(1, 1);
    cyc(1, 1);
    chk("flush_first_r_en", r_en, 1);
    cyc(0, 1);
    chk("flush_r_en_off", r_en, 0);
    chk("flush_busy", busy, 1);
    for (int k = 0; k < 10 && busy; k++) cyc(0, 1);
    chk("flush_idle_busy", busy, 0);
    chk("flush_idle_r_en", r_en, 0);
    chk("flush_words", got.size(), 1);
    chk("flush_word", got.size() > 0 ? got[0] : 8'h00, 8'h55);
    chk("flush_reads", nre, 1);
    rst();
    for (int k = 0; k < 10; k++) cyc(1, 1);
    chk("empty_r_en", nre, 0);
    chk("empty_words", got.size(), 0);
    chk("empty_m_valid", m_valid, 0);
    chk("empty_rd_count", rd_count, 0);
    chk("empty_busy", busy, 1);
    rst();
    @(posedge rclk);
    #1;
    read_error = 1;
    @(posedge rclk);
    #1;
    read_error = 0;
    repeat (3) cyc(0, 0);
    chk("err_sticky_set", err_sticky, 1);
    rst();
    chk("err_sticky_clr", err_sticky, 0);
    inf = 1;
    for (int k = 0; k < 70000 && rd_count != 16'hFFFF; k++) cyc(1, 1);
    chk("wrap_preset", rd_count, 16'hFFFF);
    chk("wrap_m_valid", m_valid, 1);
    cyc(1, 0);
    chk("wrap_rd_count", rd_count, 0);
    cyc(1, 1);
    cyc(1, 1);
    chk("midrst_r_en", r_en, 1);
    rst();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1);
      chk($sformatf("midrst_m_valid[%0d]", k), m_valid, 0);
    end
    chk("midrst_words", got.size(), 0);
    chk("r_en_while_empty", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
